// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and edge-detect a push-button into counter enable pulses with auto-repeat
module btn_conditioner #(
  parameter int DB_CYCLES  = 1000,
  parameter int RPT_DELAY  = 5000,
  parameter int RPT_PERIOD = 1000,
  parameter bit REPEAT_EN  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic en_pulse,
  output logic repeating
);
  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
  state_t state, state_nx;
  logic s1, btn_s;
  logic [CNT_W-1:0] db_cnt, rpt_cnt, rpt_cnt_nx;
  logic db_done, press_ev, rel_ev, rpt_due, en_nx;
  assign db_done  = (btn_s != btn_db) && (db_cnt == CNT_W'(DB_CYCLES - 1));
  assign press_ev = db_done && btn_s;
  assign rel_ev   = db_done && !btn_s;
  assign rpt_due  = REPEAT_EN && ((state == HOLD && rpt_cnt == CNT_W'(RPT_DELAY - 1)) ||
                                  (state == RPT  && rpt_cnt == CNT_W'(RPT_PERIOD - 1)));
  assign en_nx    = press_ev || (rpt_due && !rel_ev);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      btn_db        <= 1'b0;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_db        <= db_done ? btn_s : btn_db;
      db_cnt        <= (btn_s == btn_db || db_done) ? '0 : db_cnt + CNT_W'(1);
      press_pulse   <= press_ev;
      release_pulse <= rel_ev;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      rpt_cnt  <= '0;
      en_pulse <= 1'b0;
    end else begin
      state    <= state_nx;
      rpt_cnt  <= rpt_cnt_nx;
      en_pulse <= en_nx;
    end
  // release has priority so a repeat due in the release cycle is dropped
  always_comb begin
    state_nx   = rel_ev ? IDLE : press_ev ? HOLD : rpt_due ? RPT : state;
    rpt_cnt_nx = (rel_ev || press_ev || rpt_due || !REPEAT_EN || state == IDLE) ? '0 : rpt_cnt + CNT_W'(1);
  end
  always_comb repeating = (state == RPT);
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: randomized and directed checks of btn_conditioner against a behavioural model
module tb_btn_conditioner;
  localparam int DB = 4, RD = 10, RP = 3;
  logic clk = 1'b0, rst, btn_in;
  logic db1, pp1, rp1, en1, rep1, db0, pp0, rp0, en0, rep0;
  logic [3:0] q1, q0;
  int checks = 0, errors = 0, tcyc = 0;
  bit s1_m, s_m, db_m, pp_m, rp_m, flip, rep_due, held;
  bit hist[$];
  int p_cyc, d;

  btn_conditioner #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .REPEAT_EN(1'b1), .CNT_W(8)) d1 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db1), .press_pulse(pp1),
    .release_pulse(rp1), .en_pulse(en1), .repeating(rep1));
  btn_conditioner #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .REPEAT_EN(1'b0), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(db0), .press_pulse(pp0),
    .release_pulse(rp0), .en_pulse(en0), .repeating(rep0));

  always #5 clk = ~clk;

  // downstream 4-bit up-counters driven by each instance's en_pulse
  always @(posedge clk or negedge rst)
    if (!rst) begin
      q1 <= 4'd0;
      q0 <= 4'd0;
    end else begin
      if (en1) q1 <= q1 + 4'd1;
      if (en0) q0 <= q0 + 4'd1;
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, tcyc);
    end
  endtask

  // model: btn_s is btn_in two edges late; btn_db flips after DB consecutive differing samples;
  // repeats fall at press + RD + k*RP while the debounced level stays high
  initial forever begin
    @(posedge clk);
    tcyc++;
    if (!rst) begin
      s1_m = 0; s_m = 0; db_m = 0; pp_m = 0; rp_m = 0; p_cyc = -1000;
      hist.delete();
    end else begin
      hist.push_back(s_m);
      if (hist.size() > DB) void'(hist.pop_front());
      flip = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == db_m) flip = 0;
      pp_m = flip && !db_m;
      rp_m = flip && db_m;
      if (flip) db_m = !db_m;
      if (pp_m) p_cyc = tcyc;
      s_m = s1_m;
      s1_m = btn_in;
    end
    d = tcyc - p_cyc;
    held = db_m && d >= RD;
    rep_due = held && ((d - RD) % RP == 0);
    #1;
    chk("btn_db", int'(db1), int'(db_m));
    chk("press", int'(pp1), int'(pp_m));
    chk("release", int'(rp1), int'(rp_m));
    chk("en", int'(en1), int'(pp_m || rep_due));
    chk("repeating", int'(rep1), int'(held));
    chk("btn_db_norpt", int'(db0), int'(db_m));
    chk("press_norpt", int'(pp0), int'(pp_m));
    chk("release_norpt", int'(rp0), int'(rp_m));
    chk("en_norpt", int'(en0), int'(pp_m));
    chk("repeating_norpt", int'(rep0), 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_db(input logic v, input int t0, output int lat);
    int n = 0;
    while (db1 !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("db_wait", int'(db1), int'(v));
    lat = tcyc - t0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0, p, lat;
    rst = 1'b1; btn_in = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_in = ~btn_in;
    end
    chk("rst_outs", int'({db1, pp1, rp1, en1, rep1, db0, pp0, rp0, en0, rep0}), 0);
    @(negedge clk);
    btn_in = 1'b0; rst = 1'b1;
    cyc(10);
    chk("idle_outs", int'({db1, pp1, rp1, en1, rep1}), 0);
    chk("idle_q", int'(q1), 0);
    // clean press held 8 cycles
    t0 = tcyc; btn_in = 1'b1;
    wait_db(1'b1, t0, lat);
    chk("press_latency", lat, 6);
    chk("press_pulse_lit", int'(pp1), 1);
    chk("press_en_lit", int'(en1), 1);
    cyc(2);
    t0 = tcyc; btn_in = 1'b0;
    wait_db(1'b0, t0, lat);
    chk("release_latency", lat, 6);
    chk("release_pulse_lit", int'(rp1), 1);
    chk("release_en_lit", int'(en1), 0);
    cyc(3);
    chk("clean_q1", int'(q1), 1);
    chk("clean_q0", int'(q0), 1);
    // bounce with short runs, ending low, then settle high
    for (int k = 0; k < 10; k++) begin
      btn_in = (k % 2 == 0);
      cyc($urandom_range(1, 3));
    end
    chk("bounce_q", int'(q1), 1);
    chk("bounce_db", int'(db1), 0);
    t0 = tcyc; btn_in = 1'b1;
    wait_db(1'b1, t0, lat);
    chk("settle_latency", lat, 6);
    p = tcyc;
    cyc(1);
    chk("settle_q", int'(q1), 2);
    // auto-repeat; release lands on the repeat due at p+34
    for (int k = 2; k <= 35; k++) begin
      @(negedge clk);
      if (k == 9) chk("rep_before", int'(rep1), 0);
      if (k == 10) begin chk("rep_first_en", int'(en1), 1); chk("rep_first_rep", int'(rep1), 1); end
      if (k == 11) chk("rep_gap_en", int'(en1), 0);
      if (k == 13) chk("rep_second_en", int'(en1), 1);
      if (k == 28) btn_in = 1'b0;
      if (k == 31) chk("rep_last_en", int'(en1), 1);
      if (k == 34) begin
        chk("collide_release", int'(rp1), 1);
        chk("collide_en", int'(en1), 0);
        chk("collide_rep", int'(rep1), 0);
      end
      if (k == 35) chk("after_collide", int'({en1, rep1}), 0);
    end
    cyc(1);
    chk("repeat_q1", int'(q1), 10);
    chk("repeat_q0", int'(q0), 2);
    // reset in the middle of repeating, button still held through release
    btn_in = 1'b1; t0 = tcyc;
    wait_db(1'b1, t0, lat);
    cyc(14);
    chk("mid_rpt", int'(rep1), 1);
    #2 rst = 1'b0;
    #1 chk("async_rst_outs", int'({db1, pp1, rp1, en1, rep1, db0, pp0, rp0, en0, rep0}), 0);
    cyc(3);
    rst = 1'b1; t0 = tcyc;
    wait_db(1'b1, t0, lat);
    chk("rst_hold_latency", lat, 6);
    chk("rst_hold_en0", int'(en0), 1);
    cyc(10);
    chk("rst_hold_rep_en", int'(en1), 1);
    chk("rst_hold_rep", int'(rep1), 1);
    chk("rst_hold_norpt_en", int'(en0), 0);
    btn_in = 1'b0;
    cyc(12);
    chk("rst_hold_q1", int'(q1), 3);
    chk("rst_hold_q0", int'(q0), 1);
    // randomized runs with occasional long holds and asynchronous resets
    for (int r = 0; r < 150; r++) begin
      btn_in = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 14) + ($urandom_range(0, 5) == 0 ? 25 : 0));
      if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b0;
        cyc($urandom_range(1, 3));
        rst = 1'b1;
      end
    end
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions a raw asynchronous push-button input into clean single-cycle pulses that drive the `en` input of the 4-bit up-counter stage directly downstream.
- Pipeline: 2-flop synchronizer, counter-based debouncer, edge detector.
- Optional auto-repeat: holding the button produces periodic enable pulses.

Parameters:
- DB_CYCLES, 1000: consecutive stable synchronized cycles required to accept a level change (legal range ≥1).
- RPT_DELAY, 5000: cycles from the press pulse to the first repeat pulse.
- RPT_PERIOD, 1000: cycles between successive repeat pulses.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 means only press pulses reach en_pulse.
- CNT_W, 16: width of the internal timers. Must satisfy 2^CNT_W > max(DB_CYCLES, RPT_DELAY, RPT_PERIOD).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, released synchronously by the environment.
- btn_in  input  1  raw button level, asynchronous to clk, may bounce.
- btn_db  output  1  debounced button level (registered).
- press_pulse  output  1  one-cycle pulse on debounced 0→1.
- release_pulse  output  1  one-cycle pulse on debounced 1→0.
- en_pulse  output  1  one-cycle enable for the downstream counter: press_pulse OR repeat pulse.
- repeating  output  1  high while the FSM is in state RPT.

Behaviour:
- Reset (rst=0):
  - Synchronizer flops, btn_db, all pulses, repeating and all timers = 0.
  - FSM = IDLE.
  - Takes effect asynchronously, including mid-debounce and mid-repeat.
- Synchronizer: btn_s = btn_in delayed by 2 clk edges. No other logic may sample btn_in.
- Debounce:
  - db_cnt clears in any cycle where btn_s == btn_db; otherwise it increments.
  - When db_cnt reaches DB_CYCLES-1 with btn_s != btn_db, the next edge sets btn_db = btn_s and clears db_cnt.
  - Any mismatch run shorter than DB_CYCLES is discarded with no output change.
- Latency: a clean btn_in step is reflected on btn_db exactly 2+DB_CYCLES edges after the first edge that samples the new level.
- Pulses:
  - press_pulse and release_pulse are registered and assert in the same cycle btn_db changes. Width is exactly 1 cycle.
  - The two pulses are never high together.
- FSM states and transitions:
  - IDLE: btn_db=0. Debounced press → HOLD and reload rpt_cnt. en_pulse is driven by press_pulse.
  - HOLD: counts RPT_DELAY cycles from the press_pulse cycle, then emits a repeat pulse (en_pulse=1) and goes to RPT.
    - If REPEAT_EN=0, HOLD never advances.
  - RPT: emits en_pulse every RPT_PERIOD cycles. repeating=1.
  - Any state: debounced release (release_pulse) → IDLE in the same edge. Timers clear and repeating=0 in the release cycle.
- Simultaneous events:
  - Release wins over a repeat pulse due in the same cycle: no en_pulse in that cycle.
  - Press pulse and repeat pulse are never merged. The first repeat pulse is exactly RPT_DELAY cycles after the press pulse.
- Button held through reset deassertion: btn_db restarts at 0, so exactly one press_pulse/en_pulse follows 2+DB_CYCLES edges later. Repeat timing then starts from that pulse.
- Timers never wrap within legal parameter ranges. Reload values are constants, not accumulated.
- en_pulse is a registered output with no combinational path from btn_in to any output.

Test Plan:
- All tests use DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3, REPEAT_EN=1 unless stated.
- Reset: hold rst=0 with btn_in toggling → all outputs 0. Release rst with btn_in=0 → outputs stay 0.
- Clean press/release: btn_in 0→1 held 8 cycles, then 0 → btn_db rises 6 edges after the first sampling edge. Exactly one press_pulse and one en_pulse. Release gives exactly one release_pulse and no en_pulse.
- Bounce: btn_in toggles with runs of 1–3 cycles, then settles high → no pulses during bouncing. Exactly one press_pulse occurs 6 edges after settling. Downstream counter q goes 0→1.
- Auto-repeat: hold btn_in high 30 cycles after debounce →
  - press en_pulse at cycle P;
  - repeats at P+10, P+13, P+16, …;
  - repeating=1 from P+10;
  - counter q increments once per en_pulse;
  - on release, pulses stop and repeating falls in the release_pulse cycle.
- Release collides with a due repeat pulse → no en_pulse in that cycle; release_pulse=1; FSM in IDLE on the next cycle.
- Reset mid-repeat: assert rst during RPT → outputs 0 immediately. Release rst with btn_in still high → one press_pulse after 6 edges; repeat resumes 10 cycles later. With REPEAT_EN=0, the same hold yields only the single press en_pulse.
